// File: rtl/wb_regfile_if.sv
// Decode/MEM-WB side bundle for the writeback stage and register file.
// slave = register file side, master = pipeline (or bench) side.
interface wb_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              issue_valid;
  logic              issue_reg_write;
  logic [ADDR_W-1:0] issue_dst;
  logic              squash_valid;
  logic [ADDR_W-1:0] squash_dst;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_target;
  logic [2:0]        wb_sel;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_alu_data;
  logic [DATA_W-1:0] wb_pc_inc;
  logic [DATA_W-1:0] wb_imm;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy1;
  logic              busy2;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  modport slave (
    input  issue_valid, issue_reg_write, issue_dst, squash_valid, squash_dst,
    input  wb_reg_write, wb_target, wb_sel, wb_mem_data, wb_alu_data, wb_pc_inc, wb_imm,
    input  rd_addr1, rd_addr2,
    output rd_data1, rd_data2, busy1, busy2, wb_data, err
  );

  modport master (
    output issue_valid, issue_reg_write, issue_dst, squash_valid, squash_dst,
    output wb_reg_write, wb_target, wb_sel, wb_mem_data, wb_alu_data, wb_pc_inc, wb_imm,
    output rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, busy1, busy2, wb_data, err
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback mux + NREG-entry register file with per-register in-flight write scoreboard.
// Zero-latency write bypass to read ports; scoreboard/array update on the next edge; no backpressure.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic clk,
  input  logic rst,
  wb_regfile_if.slave bus
);
  localparam int NW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic [NW-1:0]     net    [NREG];
  logic              err_q, err_d;
  logic [DATA_W-1:0] wb_data;
  logic              sel_bad;
  logic              dec1, dec2;

  always_comb begin
    wb_data = bus.wb_alu_data;
    sel_bad = 1'b0;
    case (bus.wb_sel)
      3'b000:  wb_data = bus.wb_mem_data;
      3'b001:  wb_data = bus.wb_alu_data;
      3'b010:  wb_data = bus.wb_pc_inc;
      3'b011:  wb_data = bus.wb_imm;
      3'b100:  wb_data = DATA_W'({bus.wb_alu_data[7:0], bus.wb_imm[7:0]});
      default: sel_bad = 1'b1;
    endcase
  end

  assign dec1 = bus.wb_reg_write && (bus.rd_addr1 == bus.wb_target);
  assign dec2 = bus.wb_reg_write && (bus.rd_addr2 == bus.wb_target);

  assign bus.wb_data  = wb_data;
  assign bus.rd_data1 = dec1 ? wb_data : regs_q[bus.rd_addr1];
  assign bus.rd_data2 = dec2 ? wb_data : regs_q[bus.rd_addr2];
  // A write retiring this cycle no longer counts; a stray retire against zero reads as idle.
  assign bus.busy1    = cnt_q[bus.rd_addr1] > CNT_W'(dec1);
  assign bus.busy2    = cnt_q[bus.rd_addr2] > CNT_W'(dec2);
  assign bus.err      = err_q;

  always_comb begin
    err_d = err_q | (bus.wb_reg_write & sel_bad);
    for (int r = 0; r < NREG; r++) begin
      // Net of issue, retire and squash in NW bits; top bit set means it went negative.
      net[r] = {2'b00, cnt_q[r]}
             + NW'(bus.issue_valid & bus.issue_reg_write & (bus.issue_dst == ADDR_W'(r)))
             - NW'(bus.wb_reg_write & (bus.wb_target == ADDR_W'(r)))
             - NW'(bus.squash_valid & (bus.squash_dst == ADDR_W'(r)));
      if (net[r][NW-1]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if (net[r] > {2'b00, CNT_MAX}) begin
        cnt_d[r] = CNT_MAX;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = net[r][CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (bus.wb_reg_write) regs_q[bus.wb_target] <= wb_data;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reference model of register values, in-flight counts and
// the sticky error flag, compared every cycle, plus hand-computed literal spot checks.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  wb_regfile #(.DATA_W(16), .NREG(8), .ADDR_W(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [15:0] mreg [8];
  int          mcnt [8];
  bit          merr;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_wb();
    logic [15:0] a, m;
    a = bus.wb_alu_data;
    m = bus.wb_imm;
    case (bus.wb_sel)
      3'd0:    return bus.wb_mem_data;
      3'd1:    return a;
      3'd2:    return bus.wb_pc_inc;
      3'd3:    return m;
      3'd4:    return {a[7:0], m[7:0]};
      default: return a;
    endcase
  endfunction

  function automatic logic [15:0] m_rd(input logic [2:0] a);
    if (bus.wb_reg_write && a == bus.wb_target) return m_wb();
    return mreg[a];
  endfunction

  function automatic int m_dec(input logic [2:0] a);
    return (bus.wb_reg_write && a == bus.wb_target) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin : model_upd
    logic [15:0] w;
    int n;
    if (!rst) begin
      for (int r = 0; r < 8; r++) begin
        mreg[r] = 16'h0000;
        mcnt[r] = 0;
      end
      merr = 1'b0;
    end else begin
      w = m_wb();
      if (bus.wb_reg_write && bus.wb_sel >= 3'd5) merr = 1'b1;
      for (int r = 0; r < 8; r++) begin
        n = mcnt[r];
        if (bus.issue_valid && bus.issue_reg_write && int'(bus.issue_dst) == r) n = n + 1;
        if (bus.wb_reg_write && int'(bus.wb_target) == r) n = n - 1;
        if (bus.squash_valid && int'(bus.squash_dst) == r) n = n - 1;
        if (n > 3) begin
          n = 3;
          merr = 1'b1;
        end else if (n < 0) begin
          n = 0;
          merr = 1'b1;
        end
        mcnt[r] = n;
      end
      if (bus.wb_reg_write) mreg[bus.wb_target] = w;
    end
  end

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("cmp_wb_data", bus.wb_data, m_wb());
      chk("cmp_rd_data1", bus.rd_data1, m_rd(bus.rd_addr1));
      chk("cmp_rd_data2", bus.rd_data2, m_rd(bus.rd_addr2));
      chk("cmp_err", {15'd0, bus.err}, {15'd0, merr});
      if (mcnt[bus.rd_addr1] >= m_dec(bus.rd_addr1))
        chk("cmp_busy1", {15'd0, bus.busy1},
            {15'd0, (mcnt[bus.rd_addr1] - m_dec(bus.rd_addr1)) != 0});
      if (mcnt[bus.rd_addr2] >= m_dec(bus.rd_addr2))
        chk("cmp_busy2", {15'd0, bus.busy2},
            {15'd0, (mcnt[bus.rd_addr2] - m_dec(bus.rd_addr2)) != 0});
    end
  end

  task automatic idle();
    bus.issue_valid = 0; bus.issue_reg_write = 0; bus.issue_dst = 0;
    bus.squash_valid = 0; bus.squash_dst = 0;
    bus.wb_reg_write = 0; bus.wb_target = 0; bus.wb_sel = 0;
    bus.wb_mem_data = 0; bus.wb_alu_data = 0; bus.wb_pc_inc = 0; bus.wb_imm = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic [2:0] d);
    bus.issue_valid = 1; bus.issue_reg_write = 1; bus.issue_dst = d;
  endtask

  task automatic wb(input logic [2:0] t, input logic [2:0] s, input logic [15:0] alu);
    bus.wb_reg_write = 1; bus.wb_target = t; bus.wb_sel = s; bus.wb_alu_data = alu;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  logic [15:0] exp3 [5];

  initial begin
    exp3[0] = 16'h5555; exp3[1] = 16'h1234; exp3[2] = 16'h0042;
    exp3[3] = 16'h00AB; exp3[4] = 16'h34AB;
    idle();
    bus.rd_addr1 = 0; bus.rd_addr2 = 0;
    step();
    chk("rst_rd1", bus.rd_data1, 16'h0000);
    chk("rst_err", {15'd0, bus.err}, 16'h0000);
    rst = 1'b1;
    cmp_en = 1'b1;

    // 1: every register reads zero and idle after reset
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr1 = 3'(a); bus.rd_addr2 = 3'(7 - a);
      settle();
      chk("t1_rd1", bus.rd_data1, 16'h0000);
      chk("t1_busy1", {15'd0, bus.busy1}, 16'h0000);
      step();
    end

    // 2: bypass then array read of R5
    issue(3'd5);
    step();
    idle();
    bus.wb_reg_write = 1; bus.wb_target = 5; bus.wb_sel = 0; bus.wb_mem_data = 16'hBEEF;
    bus.rd_addr1 = 5; bus.rd_addr2 = 5;
    settle();
    chk("t2_bypass", bus.rd_data1, 16'hBEEF);
    step();
    idle();
    settle();
    chk("t2_array", bus.rd_data1, 16'hBEEF);
    chk("t2_err", {15'd0, bus.err}, 16'h0000);
    step();

    // 3: writeback select decode, then illegal select with write
    for (int s = 0; s < 5; s++) begin
      bus.wb_sel = 3'(s);
      bus.wb_alu_data = 16'h1234; bus.wb_imm = 16'h00AB;
      bus.wb_pc_inc = 16'h0042; bus.wb_mem_data = 16'h5555;
      settle();
      chk("t3_sel", bus.wb_data, exp3[s]);
      step();
    end
    idle();
    issue(3'd1);
    step();
    idle();
    wb(3'd1, 3'b110, 16'h1234);
    settle();
    chk("t3_bad_data", bus.wb_data, 16'h1234);
    chk("t3_err_pre", {15'd0, bus.err}, 16'h0000);
    step();
    idle();
    settle();
    chk("t3_err_post", {15'd0, bus.err}, 16'h0001);
    rst = 1'b0;
    #1;
    chk("t1_async_rd", bus.rd_data1, 16'h0000);
    chk("t1_async_err", {15'd0, bus.err}, 16'h0000);
    rst = 1'b1;
    step();

    // 4: two issues to R3, two retires
    bus.rd_addr1 = 3; bus.rd_addr2 = 0;
    issue(3'd3);
    settle();
    chk("t4_issue_same", {15'd0, bus.busy1}, 16'h0000);
    step();
    settle();
    chk("t4_busy_a", {15'd0, bus.busy1}, 16'h0001);
    step();
    idle();
    wb(3'd3, 3'd1, 16'h0111);
    settle();
    chk("t4_wb1_busy", {15'd0, bus.busy1}, 16'h0001);
    chk("t4_wb1_rd", bus.rd_data1, 16'h0111);
    step();
    wb(3'd3, 3'd1, 16'h0222);
    settle();
    chk("t4_wb2_busy", {15'd0, bus.busy1}, 16'h0000);
    step();
    idle();
    settle();
    chk("t4_cnt0", {15'd0, bus.busy1}, 16'h0000);
    chk("t4_rd", bus.rd_data1, 16'h0222);
    step();

    // 5: simultaneous issue/retire/squash on R2, then overflow on R6
    bus.rd_addr1 = 2; bus.rd_addr2 = 6;
    issue(3'd2);
    step();
    wb(3'd2, 3'd1, 16'h0AAA);
    bus.squash_valid = 1; bus.squash_dst = 2;
    settle();
    chk("t5_mix_busy", {15'd0, bus.busy1}, 16'h0000);
    step();
    idle();
    settle();
    chk("t5_mix_cnt", {15'd0, bus.busy1}, 16'h0000);
    chk("t5_mix_err", {15'd0, bus.err}, 16'h0000);
    step();
    for (int i = 0; i < 4; i++) begin
      issue(3'd6);
      step();
    end
    idle();
    settle();
    chk("t5_ovf_err", {15'd0, bus.err}, 16'h0001);
    chk("t5_ovf_busy", {15'd0, bus.busy2}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      wb(3'd6, 3'd1, 16'h0600 + 16'(i));
      settle();
      chk("t5_drain_busy", {15'd0, bus.busy2}, (i == 2) ? 16'h0000 : 16'h0001);
      step();
    end
    idle();
    settle();
    chk("t5_drained", {15'd0, bus.busy2}, 16'h0000);
    step();

    // 6: retire with nothing in flight
    pulse_reset();
    step();
    bus.rd_addr1 = 7; bus.rd_addr2 = 7;
    wb(3'd7, 3'd3, 16'h0000);
    bus.wb_imm = 16'h00AB;
    settle();
    chk("t6_err_pre", {15'd0, bus.err}, 16'h0000);
    step();
    idle();
    settle();
    chk("t6_rd", bus.rd_data1, 16'h00AB);
    chk("t6_err", {15'd0, bus.err}, 16'h0001);
    chk("t6_busy", {15'd0, bus.busy1}, 16'h0000);
    rst = 1'b0;
    #1;
    chk("t6_rst_err", {15'd0, bus.err}, 16'h0000);
    chk("t6_rst_rd", bus.rd_data1, 16'h0000);
    rst = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipe latch: the writeback stage plus the 8-entry architectural register file it writes.
- Each cycle it takes the registered memory data, write enable, target register and writeback-select code from the MEM/WB latch.
- It forms the writeback value, commits it to the register file, and bypasses it to the decode-stage read ports.
- It keeps a per-register in-flight write scoreboard so decode can detect RAW hazards on results not yet written back.

Parameters:
- DATA_W, 16, datapath width.
- NREG, 8, number of architectural registers.
- ADDR_W, 3, register index width.
- CNT_W, 2, scoreboard counter width; max 3 writes in flight per register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode issues an instruction into EX this cycle.
- issue_reg_write  in  1  the issued instruction writes a register.
- issue_dst  in  ADDR_W  destination of the issued instruction.
- squash_valid  in  1  an in-flight register-writing instruction is killed (branch flush).
- squash_dst  in  ADDR_W  destination of the killed instruction.
- wb_reg_write  in  1  write enable from MEM/WB.
- wb_target  in  ADDR_W  target register from MEM/WB.
- wb_sel  in  3  writeback select from MEM/WB.
- wb_mem_data  in  DATA_W  memory read data from MEM/WB.
- wb_alu_data  in  DATA_W  ALU result.
- wb_pc_inc  in  DATA_W  PC+2, for link.
- wb_imm  in  DATA_W  sign/zero-extended immediate.
- rd_addr1, rd_addr2  in  ADDR_W  decode read addresses.
- rd_data1, rd_data2  out  DATA_W  read data, bypassed.
- busy1, busy2  out  1  source register has an unretired pending write.
- wb_data  out  DATA_W  selected writeback value, combinational.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async):
  - All NREG registers clear to 0x0000.
  - All scoreboard counters clear to 0; err clears to 0.
  - Outputs reflect this state immediately.
  - Reset is honoured mid-operation; any in-flight writes are lost.
- wb_sel decode:
  - 000 = wb_mem_data.
  - 001 = wb_alu_data.
  - 010 = wb_pc_inc.
  - 011 = wb_imm.
  - 100 = {wb_alu_data[7:0], wb_imm[7:0]} (SLBI).
  - 101–111: wb_data = wb_alu_data, and err sets on that edge only if wb_reg_write=1.
- Register write: on the rising edge, if wb_reg_write=1, then reg[wb_target] <= wb_data. R0 is an ordinary register, not hardwired to zero.
- Reads are combinational.
  - rd_dataN = wb_data when wb_reg_write=1 and rd_addrN == wb_target (write-before-read bypass, zero latency).
  - Otherwise rd_dataN = reg[rd_addrN].
- Scoreboard, per register r, updated each rising edge: cnt[r] <= cnt[r] + inc − dec_wb − dec_sq.
  - inc = issue_valid & issue_reg_write & issue_dst==r.
  - dec_wb = wb_reg_write & wb_target==r.
  - dec_sq = squash_valid & squash_dst==r.
  - All three may hit the same r in one cycle; the net result applies. Example: inc+dec_wb on r gives an unchanged count.
- Overflow: if the net result exceeds 2^CNT_W−1, cnt holds at max and err sets.
- Underflow: if the net result is below 0, cnt holds at 0 and err sets. This covers a writeback or squash with no matching issue.
- busyN = (cnt[rd_addrN] − dec_wb_for_rd_addrN) != 0, i.e. a write retiring this cycle does not count as busy. A same-cycle issue to rd_addrN does not raise busyN until the next cycle.
- err is sticky until reset.
- Latency:
  - Writeback data is visible on the read ports in the same cycle via bypass, and from the register array on the next cycle.
  - The scoreboard reflects issue one cycle after the issue edge.

Test Plan:
1. Reset, then read all 8 regs -> all rd_data 0x0000, busy 0, err 0. Assert rst low mid-test after writes -> regs read 0x0000 immediately, without waiting for a clock edge.
2. wb_reg_write=1, wb_target=5, wb_sel=000, wb_mem_data=0xBEEF, rd_addr1=5 -> rd_data1=0xBEEF the same cycle (bypass). Next cycle, with wb_reg_write=0 -> still 0xBEEF.
3. Each wb_sel with alu=0x1234, imm=0x00AB, pc_inc=0x0042, mem=0x5555 -> wb_data = 0x5555, 0x1234, 0x0042, 0x00AB, 0x34AB. wb_sel=110 with write -> wb_data=0x1234, err=1 after the edge.
4. Issue to R3 twice -> busy1 (rd_addr1=3) = 1.
   - First writeback to R3 -> busy stays 1.
   - Second writeback cycle -> busy1=0 combinationally.
   - After the edge, cnt[3]=0.
5. Same cycle: issue R2, writeback R2, squash R2 with cnt[2]=1 -> cnt[2]=0, err=0. Four issues to R6 with no retire -> cnt holds 3, err=1.
6. Writeback to R7 with cnt[7]=0 -> R7 written, cnt stays 0, err=1. Then reset -> err=0.
